// File: rtl/inst_ram.sv
// Loadable instruction memory: byte-serial boot loader plus a registered,
// word-aligned fetch port with stall hold and misaligned/out-of-range error flag.
module inst_ram #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic [ADDR_W:0]   load_words,
    output logic              ovf,
    input  logic [31:0]       a,
    input  logic              en,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              fetch_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t              state;
    logic [1:0]          bcnt;
    logic [23:0]         asm_q;
    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                word_done;
    logic                wr_en;
    logic [31:0]         word;
    logic                fetch_bad;
    logic [ADDR_W-1:0]   ridx;

    assign ld_ready  = (state == LOAD) && !ld_start;
    assign accept    = ld_valid && ld_ready;
    assign word_done = accept && ((bcnt == 2'd3) || ld_last);
    assign wr_en     = word_done && (load_words < CW'(DEPTH));
    assign fetch_bad = (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
    assign ridx      = a[ADDR_W+1:2];

    // Assemble the word big-endian, zero-padding low bytes on a short final word
    always_comb begin
        word = '0;
        unique case (bcnt)
            2'd0:    word = {ld_byte, 24'h0};
            2'd1:    word = {asm_q[7:0], ld_byte, 16'h0};
            2'd2:    word = {asm_q[15:0], ld_byte, 8'h0};
            default: word = {asm_q, ld_byte};
        endcase
    end

    // Array is deliberately not reset so it survives an aborted load
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[load_words[ADDR_W-1:0]] <= word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bcnt       <= '0;
            asm_q      <= '0;
            load_words <= '0;
            ovf        <= 1'b0;
            inst       <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
        end else if (ld_start) begin
            state      <= LOAD;
            bcnt       <= '0;
            load_words <= '0;
            ovf        <= 1'b0;
            inst       <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        asm_q <= {asm_q[15:0], ld_byte};
                        bcnt  <= ld_last ? 2'd0 : 2'(bcnt + 2'd1);
                        if (word_done) begin
                            if (wr_en) begin
                                load_words <= load_words + CW'(1);
                            end else begin
                                ovf <= 1'b1;
                            end
                        end
                        if (ld_last) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        inst_valid <= 1'b1;
                        fetch_err  <= fetch_bad;
                        inst       <= fetch_bad ? 32'h0 : mem[ridx];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_ram.sv
// Scoreboard bench for inst_ram: driver pushes expected snapshots from a
// program-level model, a monitor pops and compares them on the falling edge.
module tb_inst_ram;

    localparam int unsigned ADDR_W = 6;
    localparam int          DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_start;
    logic              ld_valid;
    logic              ld_ready;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic [ADDR_W:0]   load_words;
    logic              ovf;
    logic [31:0]       a;
    logic              en;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              fetch_err;

    always #5 clk = ~clk;

    inst_ram #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_byte(ld_byte), .ld_last(ld_last),
        .load_words(load_words), .ovf(ovf), .a(a), .en(en), .inst(inst),
        .inst_valid(inst_valid), .fetch_err(fetch_err)
    );

    typedef struct {
        int unsigned cyc;
        logic [31:0] inst;
        logic        valid;
        logic        err;
        int          words;
        logic        ovf;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          passed = 0;

    // Reference model: program-level view of memory and visible state
    logic [31:0] m_mem [DEPTH];
    bit          m_run;
    logic [31:0] m_inst;
    bit          m_valid;
    bit          m_err;
    int          m_words;
    bit          m_ovf;
    logic [7:0]  prog[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endfunction

    task automatic push_exp();
        exp_t e;
        e.cyc   = cyc + 1;
        e.inst  = m_inst;
        e.valid = m_valid;
        e.err   = m_err;
        e.words = m_words;
        e.ovf   = m_ovf;
        sbq.push_back(e);
    endtask

    task automatic model_clear();
        m_run = 0; m_inst = '0; m_valid = 0; m_err = 0; m_words = 0; m_ovf = 0;
    endtask

    // Monitor
    initial forever begin
        @(negedge clk);
        while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            chk("inst", inst, e.inst);
            chk("inst_valid", 32'(inst_valid), 32'(e.valid));
            chk("fetch_err", 32'(fetch_err), 32'(e.err));
            chk("load_words", 32'(load_words), 32'(e.words));
            chk("ovf", 32'(ovf), 32'(e.ovf));
        end
    end

    task automatic reset_checks(string tag);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
        chk({tag, "_err"}, 32'(fetch_err), 32'h0);
        chk({tag, "_ready"}, 32'(ld_ready), 32'h0);
        chk({tag, "_words"}, 32'(load_words), 32'h0);
        chk({tag, "_ovf"}, 32'(ovf), 32'h0);
    endtask

    // Stream prog[]; the model is updated from the whole byte list afterwards
    task automatic load_prog(input int gap_max, input bit do_start);
        int n;
        int nw;
        logic [31:0] w32;
        n = prog.size();
        if (do_start) begin
            @(negedge clk);
            ld_start = 1; ld_valid = 0; en = 0;
            model_clear();
            @(negedge clk);
            ld_start = 0;
        end
        for (int i = 0; i < n; i++) begin
            ld_valid = 0; ld_last = 0;
            repeat ($urandom_range(gap_max)) @(negedge clk);
            ld_valid = 1; ld_byte = prog[i]; ld_last = (i == n - 1);
            @(negedge clk);
        end
        ld_valid = 0; ld_last = 0;
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            w32 = '0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < n) w32[31 - 8 * k -: 8] = prog[4 * w + k];
            if (w < DEPTH) m_mem[w] = w32;
        end
        m_words = (nw > DEPTH) ? DEPTH : nw;
        m_ovf   = (nw > DEPTH);
        m_run   = 1;
        push_exp();
    endtask

    task automatic rand_prog(input int nbytes);
        prog = {};
        for (int i = 0; i < nbytes; i++) prog.push_back(8'($urandom));
    endtask

    task automatic fetch(input logic [31:0] addr, input logic e);
        @(negedge clk);
        a = addr; en = e;
        if (m_run && e) begin
            m_valid = 1;
            if ((addr % 4) != 0 || addr >= 32'(DEPTH * 4)) begin
                m_err = 1; m_inst = '0;
            end else begin
                m_err = 0; m_inst = m_mem[addr / 4];
            end
        end
        push_exp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; ld_start = 0; ld_valid = 0; ld_last = 0; ld_byte = '0; a = '0; en = 0;
        model_clear();
        repeat (2) @(negedge clk);
        reset_checks("por");
        rst = 0;
        fetch(32'h0, 1);

        prog = {8'h14, 8'h00, 8'h08, 8'h01, 8'h14, 8'h00, 8'h24, 8'h22};
        load_prog(0, 1);
        fetch(32'h0, 1);
        fetch(32'h4, 1);

        prog = {8'h00, 8'h10, 8'h0C, 8'h41, 8'hAB};
        load_prog(2, 1);
        fetch(32'h4, 1);
        fetch(32'h0, 1);

        rand_prog(24 * 4 + 2);
        load_prog(3, 1);
        fetch(32'h4, 1);
        repeat (3) fetch(32'h8, 0);
        fetch(32'h8, 1);
        fetch(32'h2, 1);
        fetch(32'h100, 1);
        fetch(32'h0, 1);

        for (int i = 0; i < 150; i++) begin
            int r;
            logic [31:0] ad;
            r = $urandom_range(7);
            if (r == 0)      ad = ($urandom_range(m_words - 1) * 4) + $urandom_range(1, 3);
            else if (r == 1) ad = 32'(DEPTH * 4) + ($urandom & 32'h0FFF_FFFC);
            else             ad = $urandom_range(m_words - 1) * 4;
            fetch(ad, $urandom_range(3) != 0);
        end

        rand_prog(66 * 4 + 3);
        load_prog(1, 1);
        fetch(32'hFC, 1);
        fetch(32'h0, 1);
        fetch(32'h100, 1);

        // ld_start clears ovf; then abort that load with an asynchronous reset
        @(negedge clk);
        ld_start = 1; en = 0;
        model_clear();
        push_exp();
        @(negedge clk);
        ld_start = 0;
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1; ld_byte = 8'(i + 1);
            @(negedge clk);
        end
        ld_valid = 0;
        #2 rst = 1;
        #1 reset_checks("async");
        @(negedge clk);
        rst = 0;
        model_clear();
        fetch(32'h0, 1);

        // Byte offered alongside ld_start must be dropped
        @(negedge clk);
        ld_start = 1; ld_valid = 1; ld_byte = 8'hEE; en = 0;
        #1 chk("ready_on_start", 32'(ld_ready), 32'h0);
        model_clear();
        @(negedge clk);
        ld_start = 0; ld_valid = 0;
        #1 chk("ready_in_load", 32'(ld_ready), 32'h1);
        prog = {8'h11, 8'h22, 8'h33, 8'h44};
        load_prog(0, 0);
        fetch(32'h0, 1);

        repeat (3) @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
